mem_split_unit: RTL and testbench

Parametrised memory-access stage that sits between the address-generation stage and writeback and drives the data cache. Every load or store whose bytes cross a cache-line boundary is split into two tagged cache requests. Load pieces are merged back into one right-justified result, and store data is split across the two pieces. Unlike the previous fixed 32-bit two-state memory stage, it adds a request/ready handshake, tag-matched responses, kill handling and store splitting.

---
 rtl/mem_split_unit.sv | 152 +++++++++++++++
 tb/tb_mem_split_unit.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_split_unit.sv
// mem_split_unit: memory stage that splits line-crossing loads and stores
// into two tagged cache requests and merges load pieces into one result.
// Ports: i_* uop from address generation, o_stall/o_v/o_data to pipeline,
// o_req_*/i_req_rdy cache request channel, i_rsp_* cache responses.
module mem_split_unit #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 15,
  parameter int LINE_BYTES = 16,
  parameter int TAG_W      = 3,
  parameter int SZ_W       = $clog2(DATA_W/8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_v,
  input  logic              i_rd,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [SZ_W-1:0]   i_size,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_kill,
  output logic              o_stall,
  output logic              o_v,
  output logic [DATA_W-1:0] o_data,
  output logic              o_req_v,
  input  logic              i_req_rdy,
  output logic              o_req_wr,
  output logic [ADDR_W-1:0] o_req_addr,
  output logic [SZ_W-1:0]   o_req_size,
  output logic [DATA_W-1:0] o_req_wdata,
  output logic [TAG_W-1:0]  o_req_tag,
  input  logic              i_rsp_v,
  input  logic [TAG_W-1:0]  i_rsp_tag,
  input  logic [DATA_W-1:0] i_rsp_data
);

  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int SH_W  = OFF_W + 4;
  localparam logic [OFF_W:0] LB = (OFF_W+1)'(LINE_BYTES);
  localparam logic [SZ_W-1:0] SZ_MAX = SZ_W'(DATA_W/8 - 1);
  localparam logic [DATA_W-1:0] ONES = {DATA_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE, WAIT1, REQ2, WAIT2, DONE
  } state_t;

  state_t state;

  logic [TAG_W-1:0]  tag_q;
  logic [TAG_W-1:0]  pend_q;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] data_q;
  logic              v_q;

  logic              mem;
  logic [OFF_W-1:0]  off;
  logic [OFF_W:0]    sum;
  logic [OFF_W:0]    n1;
  logic              spill;
  logic [SH_W-1:0]   sh;
  logic [SZ_W-1:0]   sz_gap;
  logic [DATA_W-1:0] sz_mask;
  logic [DATA_W-1:0] n1_mask;
  logic [SZ_W-1:0]   p1_size;
  logic [SZ_W-1:0]   p2_size;
  logic [ADDR_W-1:0] p2_addr;
  logic [DATA_W-1:0] p2_wdata;
  logic              in_p2;
  logic              acc;
  logic              rsp_hit;

  assign mem   = i_v & (i_rd | i_wr);
  assign off   = i_addr[OFF_W-1:0];
  assign sum   = {1'b0, off} + (OFF_W+1)'(i_size);
  assign spill = sum >= LB;
  assign n1    = LB - {1'b0, off};
  assign sh    = {n1, 3'b000};

  // keep the low i_size+1 bytes / the low n1 bytes
  assign sz_gap  = SZ_MAX - i_size;
  assign sz_mask = ONES >> {sz_gap, 3'b000};
  assign n1_mask = ~(ONES << sh);

  assign p1_size  = spill ? SZ_W'(n1 - 1'b1) : i_size;
  assign p2_size  = i_size - SZ_W'(n1);
  assign p2_addr  = i_addr + ADDR_W'(n1);
  assign p2_wdata = i_wdata >> sh;

  assign in_p2 = (state == REQ2);

  assign o_req_v = ~rst & ~i_kill & mem &
                   ((state == IDLE) | in_p2);
  assign o_req_wr    = i_wr;
  assign o_req_addr  = in_p2 ? p2_addr : i_addr;
  assign o_req_size  = in_p2 ? p2_size : p1_size;
  assign o_req_wdata = in_p2 ? p2_wdata : i_wdata;
  assign o_req_tag   = tag_q;

  assign acc     = o_req_v & i_req_rdy;
  assign rsp_hit = i_rsp_v & (i_rsp_tag == pend_q);

  assign o_stall = ~rst & mem & (state != DONE) & ~i_kill;
  assign o_v     = v_q & ~i_kill & ~rst;
  assign o_data  = data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      tag_q  <= '0;
      pend_q <= '0;
      hold_q <= '0;
      data_q <= '0;
      v_q    <= 1'b0;
    end else begin
      v_q <= 1'b0;
      if (acc) begin
        tag_q  <= tag_q + 1'b1;
        pend_q <= tag_q;
      end
      if (i_kill) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: if (acc) state <= WAIT1;
          WAIT1: begin
            if (rsp_hit) begin
              if (spill) begin
                hold_q <= i_rsp_data & n1_mask;
                state  <= REQ2;
              end else begin
                data_q <= i_wr ? '0 : (i_rsp_data & sz_mask);
                v_q    <= 1'b1;
                state  <= DONE;
              end
            end
          end
          REQ2: if (acc) state <= WAIT2;
          WAIT2: begin
            if (rsp_hit) begin
              data_q <= i_wr ? '0 :
                ((hold_q | (i_rsp_data << sh)) & sz_mask);
              v_q    <= 1'b1;
              state  <= DONE;
            end
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_split_unit.sv
// tb_mem_split_unit: randomized and directed bench for mem_split_unit
// with a byte-level memory model acting as the data cache.
module tb_mem_split_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_v = 1'b0, i_rd = 1'b0, i_wr = 1'b0;
  logic [14:0] i_addr = '0;
  logic [1:0]  i_size = '0;
  logic [31:0] i_wdata = '0;
  logic        i_kill = 1'b0;
  logic        o_stall, o_v;
  logic [31:0] o_data;
  logic        o_req_v;
  logic        i_req_rdy = 1'b0;
  logic        o_req_wr;
  logic [14:0] o_req_addr;
  logic [1:0]  o_req_size;
  logic [31:0] o_req_wdata;
  logic [2:0]  o_req_tag;
  logic        i_rsp_v = 1'b0;
  logic [2:0]  i_rsp_tag = '0;
  logic [31:0] i_rsp_data = '0;

  always #5 clk = ~clk;

  mem_split_unit dut (
    .clk(clk), .rst(rst),
    .i_v(i_v), .i_rd(i_rd), .i_wr(i_wr),
    .i_addr(i_addr), .i_size(i_size),
    .i_wdata(i_wdata), .i_kill(i_kill),
    .o_stall(o_stall), .o_v(o_v), .o_data(o_data),
    .o_req_v(o_req_v), .i_req_rdy(i_req_rdy),
    .o_req_wr(o_req_wr), .o_req_addr(o_req_addr),
    .o_req_size(o_req_size),
    .o_req_wdata(o_req_wdata), .o_req_tag(o_req_tag),
    .i_rsp_v(i_rsp_v), .i_rsp_tag(i_rsp_tag),
    .i_rsp_data(i_rsp_data)
  );

  typedef struct {
    bit rst, v, rd, wr, kill, rdy, rsp_v;
    logic [14:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [2:0]  rsp_tag;
    logic [31:0] rsp_data;
    bit e_stall, e_req_v, e_req_wr, e_v, chk_data;
    logic [14:0] e_addr;
    logic [1:0]  e_size;
    logic [31:0] e_wdata, e_data;
    logic [2:0]  e_tag;
  } cyc_t;

  typedef struct {
    logic        wr;
    logic [14:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [2:0]  tag;
  } req_t;

  logic [7:0] mem [0:32767];
  cyc_t q[$];
  req_t log_q[$];
  cyc_t cur;
  bit   chk_on = 0;
  int   checks = 0, failures = 0;
  int   cyc_cnt = 0, nv = 0, last_v_cyc = 0;
  logic [31:0] last_data = '0;
  logic [2:0]  model_tag = '0;
  logic [2:0]  stale = '0;
  bit   have_stale = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc_cnt, got, exp);
    end
  endtask

  function automatic req_t get_log(input int i);
    req_t r;
    r = '{default:0};
    if (i < log_q.size()) r = log_q[i];
    return r;
  endfunction

  // single compare process: every played cycle checked at negedge
  always @(negedge clk) begin
    if (chk_on) begin
      chk("stall", o_stall, cur.e_stall);
      chk("req_v", o_req_v, cur.e_req_v);
      if (cur.e_req_v) begin
        chk("req_addr", o_req_addr, cur.e_addr);
        chk("req_size", o_req_size, cur.e_size);
        chk("req_tag", o_req_tag, cur.e_tag);
        chk("req_wr", o_req_wr, cur.e_req_wr);
        chk("req_wdata", o_req_wdata, cur.e_wdata);
      end
      chk("o_v", o_v, cur.e_v);
      if (cur.e_v || cur.chk_data) chk("o_data", o_data, cur.e_data);
      if (o_req_v && i_req_rdy && !rst)
        log_q.push_back('{o_req_wr, o_req_addr, o_req_size,
                          o_req_wdata, o_req_tag});
      if (o_v) begin
        nv++;
        last_data = o_data;
        last_v_cyc = cyc_cnt;
      end
      chk_on = 0;
    end
  end

  task automatic play();
    cyc_t r;
    while (q.size() > 0) begin
      r = q.pop_front();
      @(posedge clk);
      #1;
      rst = r.rst; i_v = r.v; i_rd = r.rd; i_wr = r.wr;
      i_addr = r.addr; i_size = r.size; i_wdata = r.wdata;
      i_kill = r.kill; i_req_rdy = r.rdy; i_rsp_v = r.rsp_v;
      i_rsp_tag = r.rsp_tag; i_rsp_data = r.rsp_data;
      cur = r;
      cyc_cnt++;
      chk_on = 1;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic set_word(input logic [14:0] a, input logic [31:0] w);
    for (int j = 0; j < 4; j++) mem[a + 15'(j)] = w[8*j +: 8];
  endtask

  function automatic cyc_t idle_rec(input bit nonmem);
    cyc_t r;
    r = '{default:0};
    r.v = nonmem;
    r.addr = 15'($urandom);
    r.rdy = 1'($urandom);
    r.rsp_v = 1'($urandom);
    r.rsp_tag = 3'($urandom);
    r.rsp_data = $urandom;
    return r;
  endfunction

  task automatic do_reset();
    cyc_t r;
    r = '{default:0};
    r.rst = 1;
    q.push_back(r);
    r.rst = 0;
    r.chk_data = 1;
    q.push_back(r);
    play();
    model_tag = '0;
    have_stale = 0;
  endtask

  // builds the cycle list for one uop from byte-level rules
  task automatic run_uop(
    input logic [14:0] addr, input logic [1:0] size,
    input bit wr, input logic [31:0] wdata,
    input int st1, input int wt1, input int st2, input int wt2,
    input bit stray, input logic [2:0] stray_tag,
    input int kill_at, input int rst_at);
    cyc_t base, r;
    int n1, np, ps, st, wt, nacc;
    logic [14:0] pa;
    logic [31:0] pw, res;
    logic [2:0] t, pend, last_acc;
    n1 = 0;
    for (int k = 0; k <= int'(size); k++)
      if (((addr + 15'(k)) >> 4) == (addr >> 4)) n1++;
    np = (n1 <= int'(size)) ? 2 : 1;
    if (stray && wt1 < 1) wt1 = 1;
    base = '{default:0};
    base.v = 1; base.rd = !wr; base.wr = wr;
    base.addr = addr; base.size = size; base.wdata = wdata;
    base.e_stall = 1;
    t = model_tag;
    for (int p = 0; p < np; p++) begin
      pa = (p == 0) ? addr : addr + 15'(n1);
      ps = (np == 1) ? int'(size) :
           (p == 0) ? n1 - 1 : int'(size) - n1;
      pw = (p == 0) ? wdata : wdata >> (8 * n1);
      st = (p == 0) ? st1 : st2;
      wt = (p == 0) ? wt1 : wt2;
      r = base;
      r.e_req_v = 1; r.e_req_wr = wr; r.e_addr = pa;
      r.e_size = 2'(ps); r.e_wdata = pw; r.e_tag = t;
      for (int i = 0; i < st; i++) q.push_back(r);
      r.rdy = 1;
      q.push_back(r);
      pend = t;
      t = t + 3'd1;
      r = base;
      for (int i = 0; i < wt; i++) begin
        r.rdy = 1'($urandom);
        r.rsp_v = stray && p == 0 && i == 0;
        r.rsp_tag = stray_tag;
        r.rsp_data = $urandom;
        q.push_back(r);
      end
      r.rdy = 1'($urandom);
      r.rsp_v = 1; r.rsp_tag = pend;
      r.rsp_data = $urandom;
      for (int j = 0; j <= ps; j++)
        r.rsp_data[8*j +: 8] = mem[pa + 15'(j)];
      q.push_back(r);
    end
    res = '0;
    if (!wr)
      for (int k = 0; k <= int'(size); k++)
        res[8*k +: 8] = mem[addr + 15'(k)];
    r = base;
    r.e_stall = 0; r.e_v = 1; r.e_data = res;
    q.push_back(r);
    if (kill_at >= 0 && kill_at < q.size()) begin
      while (q.size() > kill_at + 1) void'(q.pop_back());
      r = q[kill_at];
      r.kill = 1; r.e_stall = 0; r.e_req_v = 0; r.e_v = 0;
      q[kill_at] = r;
    end else if (rst_at >= 0 && rst_at < q.size()) begin
      while (q.size() > rst_at + 1) void'(q.pop_back());
      r = q[rst_at];
      r.rst = 1; r.e_stall = 0; r.e_req_v = 0; r.e_v = 0;
      q[rst_at] = r;
      r = '{default:0};
      r.chk_data = 1;
      q.push_back(r);
    end
    nacc = 0;
    last_acc = '0;
    foreach (q[i])
      if (q[i].e_req_v && q[i].rdy) begin
        nacc++;
        last_acc = q[i].e_tag;
      end
    if (rst_at >= 0 && rst_at < q.size()) begin
      model_tag = '0;
      have_stale = 0;
    end else begin
      model_tag = model_tag + 3'(nacc);
      if (kill_at >= 0 && nacc > 0) begin
        stale = last_acc;
        have_stale = 1;
      end
    end
    play();
  endtask

  int s0, nv0;
  logic [14:0] ra;
  logic [2:0]  stag;
  bit          sen;

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
    do_reset();

    // aligned load
    set_word(15'h0010, 32'hDEADBEEF);
    log_q.delete();
    s0 = cyc_cnt + 1;
    run_uop(15'h0010, 2'd3, 0, '0, 0, 0, 0, 0, 0, '0, -1, -1);
    chk("t1_nreq", log_q.size(), 1);
    chk("t1_addr", get_log(0).addr, 15'h0010);
    chk("t1_size", get_log(0).size, 2'd3);
    chk("t1_tag", get_log(0).tag, 3'd0);
    chk("t1_data", last_data, 32'hDEADBEEF);
    chk("t1_lat", last_v_cyc - s0, 2);

    // spill load
    do_reset();
    set_word(15'h001E, 32'hDEADBEEF);
    log_q.delete();
    s0 = cyc_cnt + 1;
    run_uop(15'h001E, 2'd3, 0, '0, 0, 0, 0, 0, 0, '0, -1, -1);
    chk("t2_nreq", log_q.size(), 2);
    chk("t2_a1", get_log(0).addr, 15'h001E);
    chk("t2_s1", get_log(0).size, 2'd1);
    chk("t2_a2", get_log(1).addr, 15'h0020);
    chk("t2_s2", get_log(1).size, 2'd1);
    chk("t2_t2", get_log(1).tag, 3'd1);
    chk("t2_data", last_data, 32'hDEADBEEF);
    chk("t2_lat", last_v_cyc - s0, 4);

    // spill store
    do_reset();
    log_q.delete();
    nv0 = nv;
    run_uop(15'h000D, 2'd3, 1, 32'h11223344,
            0, 0, 0, 0, 0, '0, -1, -1);
    chk("t3_wr", get_log(0).wr, 1);
    chk("t3_a1", get_log(0).addr, 15'h000D);
    chk("t3_s1", get_log(0).size, 2'd2);
    chk("t3_w1", get_log(0).wdata[23:0], 24'h223344);
    chk("t3_a2", get_log(1).addr, 15'h0010);
    chk("t3_s2", get_log(1).size, 2'd0);
    chk("t3_w2", get_log(1).wdata[7:0], 8'h11);
    chk("t3_nv", nv - nv0, 1);
    chk("t3_data", last_data, 32'h0);

    // back-pressure and stale tag 5
    do_reset();
    set_word(15'h0040, 32'h12345678);
    log_q.delete();
    run_uop(15'h0040, 2'd3, 0, '0, 3, 1, 0, 0, 1, 3'd5, -1, -1);
    chk("t4_nreq", log_q.size(), 1);
    chk("t4_data", last_data, 32'h12345678);

    // kill in WAIT2, then reissue with a stale response
    do_reset();
    set_word(15'h001E, 32'hDEADBEEF);
    nv0 = nv;
    run_uop(15'h001E, 2'd3, 0, '0, 0, 0, 0, 1, 0, '0, 3, -1);
    chk("t5_nov", nv - nv0, 0);
    set_word(15'h001E, 32'hDDCCBBAA);
    log_q.delete();
    run_uop(15'h001E, 2'd3, 0, '0, 0, 1, 0, 0,
            have_stale, stale, -1, -1);
    have_stale = 0;
    chk("t5_tag", get_log(0).tag, 3'd2);
    chk("t5_data", last_data, 32'hDDCCBBAA);

    // reset in WAIT1
    run_uop(15'h0040, 2'd3, 0, '0, 0, 2, 0, 0, 0, '0, -1, 1);
    log_q.delete();
    run_uop(15'h0044, 2'd1, 0, '0, 0, 0, 0, 0, 0, '0, -1, -1);
    chk("t6_tag", get_log(0).tag, 3'd0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        q.push_back(idle_rec(0));
        play();
      end else if (kind == 1) begin
        q.push_back(idle_rec(1));
        play();
      end else begin
        ra = 15'($urandom);
        if ($urandom_range(0, 1) == 1) ra[3:0] = 4'(12 + $urandom_range(0, 3));
        if ($urandom_range(0, 15) == 0) ra[14:4] = '1;
        if (have_stale) begin
          sen = 1;
          stag = stale;
          have_stale = 0;
        end else begin
          sen = ($urandom_range(0, 3) == 0);
          stag = model_tag + 3'(1 + $urandom_range(0, 6));
        end
        run_uop(ra, 2'($urandom), 1'($urandom), $urandom,
                $urandom_range(0, 2), $urandom_range(0, 2),
                $urandom_range(0, 2), $urandom_range(0, 2),
                sen, stag,
                ($urandom_range(0, 9) == 0) ? $urandom_range(0, 9) : -1,
                ($urandom_range(0, 29) == 0) ? $urandom_range(0, 9) : -1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
